// File: rtl/vram_init_if.sv
// vram_init_if: request, character-stream and video RAM write-port signals of vram_init.
// master drives requests and characters; slave is the vram_init side.
interface vram_init_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              clr;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        attr;
  logic              ch_valid;
  logic [7:0]        ch_data;
  logic              ch_last;
  logic              ch_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              vram_we;
  logic              disp_rst;
  logic              busy;
  logic              done;

  modport master (
    output start, clr, start_addr, attr, ch_valid, ch_data, ch_last,
    input  ch_ready, vram_addr, vram_data, vram_we, disp_rst, busy, done
  );

  modport slave (
    input  start, clr, start_addr, attr, ch_valid, ch_data, ch_last,
    output ch_ready, vram_addr, vram_data, vram_we, disp_rst, busy, done
  );
endinterface

// File: rtl/vram_init.sv
// vram_init: clears text-mode video RAM after reset, then writes attributed character strings.
// Build macro VRAM_INIT_NEWLINE_EN makes 8'h0A move the cursor to the next row instead of writing.
module vram_init #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 16,
  parameter logic [15:0] FILL_WORD   = 16'h3000,
  parameter int          HOLD_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  vram_init_if.slave  io_bus
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(CELLS);
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur, w_cur_nxt, w_cur_inc, w_cur_load, w_nl_addr;
  logic [7:0]        r_attr, w_attr_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_we, w_we_nxt;
  logic              r_done, w_done_nxt;
  logic              r_init_done, w_init_done_nxt;
  logic              r_busy, r_ready, r_disp_rst;
  logic              w_is_nl;
  logic [HOLD_W-1:0] r_hold;

  // r_cur is the clear address in CLEAR and the string cursor in STREAM.
  assign w_cur_inc  = (r_cur == LAST_ADDR) ? '0 : r_cur + ADDR_W'(1);
  assign w_cur_load = ({1'b0, io_bus.start_addr} >= CELLS_EXT) ? '0 : io_bus.start_addr;

`ifdef VRAM_INIT_NEWLINE_EN
  logic [ADDR_W-1:0] w_row_base;
  assign w_row_base = r_cur - (r_cur % ADDR_W'(COLS));
  assign w_nl_addr  = (w_row_base == ADDR_W'(CELLS - COLS)) ? '0 : w_row_base + ADDR_W'(COLS);
  assign w_is_nl    = (io_bus.ch_data == 8'h0A);
`else
  assign w_nl_addr  = w_cur_inc;
  assign w_is_nl    = 1'b0;
`endif

  // Next-state, cursor and write-port decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_attr_nxt      = r_attr;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_done_nxt      = 1'b0;
    w_init_done_nxt = r_init_done;
    case (r_state)
      S_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cur;
        w_data_nxt = DATA_W'(FILL_WORD);
        if (r_cur == LAST_ADDR) begin
          w_state_nxt     = S_IDLE;
          w_cur_nxt       = '0;
          w_done_nxt      = 1'b1;
          w_init_done_nxt = 1'b1;
        end else begin
          w_cur_nxt = w_cur_inc;
        end
      end
      S_IDLE: begin
        if (io_bus.clr) begin
          w_state_nxt = S_CLEAR;
          w_cur_nxt   = '0;
        end else if (io_bus.start) begin
          w_state_nxt = S_STREAM;
          w_cur_nxt   = w_cur_load;
          w_attr_nxt  = io_bus.attr;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (io_bus.ch_valid) begin
          if (w_is_nl) begin
            w_cur_nxt = w_nl_addr;
          end else begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = r_cur;
            w_data_nxt = DATA_W'({r_attr, io_bus.ch_data});
            w_cur_nxt  = w_cur_inc;
          end
          if (io_bus.ch_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cur_nxt   = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Cursor, latched attribute and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur       <= '0;
      r_attr      <= 8'h00;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_cur       <= w_cur_nxt;
      r_attr      <= w_attr_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_ready     <= (w_state_nxt == S_STREAM);
    end
  end

  // Display reset: released once the first clear is over and the hold time has run out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold     <= '0;
      r_disp_rst <= 1'b1;
    end else begin
      r_hold     <= (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);
      r_disp_rst <= r_disp_rst & ~(r_init_done & (r_hold == HOLD_MAX));
    end
  end

  assign io_bus.vram_we   = r_we;
  assign io_bus.vram_addr = r_addr;
  assign io_bus.vram_data = r_data;
  assign io_bus.done      = r_done;
  assign io_bus.busy      = r_busy;
  assign io_bus.ch_ready  = r_ready;
  assign io_bus.disp_rst  = r_disp_rst;

endmodule

// File: tb/tb_vram_init.sv
// tb_vram_init: random and directed strings for vram_init, checked cycle by cycle
// against an integer-arithmetic reference model of the clear/string behaviour.
module tb_vram_init;
  localparam int          COLS   = 80;
  localparam int          ROWS   = 30;
  localparam int          CELLS  = COLS * ROWS;
  localparam int          ADDR_W = 12;
  localparam int          DATA_W = 16;
  localparam int          HOLD   = 8;
  localparam logic [15:0] FILL   = 16'h3000;
`ifdef VRAM_INIT_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif
  localparam int M_CLEAR = 0, M_IDLE = 1, M_STREAM = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_init_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_init #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FILL_WORD(FILL), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state and expected outputs for the current cycle
  int m_mode, m_idx, m_cur, m_attr, m_since;
  bit m_clear_ok;
  bit e_we, e_done, e_busy, e_ready, e_disp;
  int e_addr, e_data;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit cleared_before;
    if (rst) begin
      m_mode = M_CLEAR; m_idx = 0; m_since = 0; m_clear_ok = 1'b0;
      e_we = 1'b0; e_addr = 0; e_data = 0; e_done = 1'b0; e_disp = 1'b1;
    end else begin
      cleared_before = m_clear_ok;
      m_since++;
      if (cleared_before && (m_since - 1) >= HOLD) e_disp = 1'b0;
      e_we = 1'b0; e_done = 1'b0;
      case (m_mode)
        M_CLEAR: begin
          e_we = 1'b1; e_addr = m_idx; e_data = FILL;
          m_idx++;
          if (m_idx == CELLS) begin
            m_mode = M_IDLE; e_done = 1'b1; m_clear_ok = 1'b1;
          end
        end
        M_IDLE: begin
          if (bus.clr) begin
            m_mode = M_CLEAR; m_idx = 0;
          end else if (bus.start) begin
            m_mode = M_STREAM;
            m_cur  = (int'(bus.start_addr) < CELLS) ? int'(bus.start_addr) : 0;
            m_attr = int'(bus.attr);
          end
        end
        default: begin
          if (bus.ch_valid) begin
            if (NL_EN && bus.ch_data == 8'h0A) begin
              m_cur = ((m_cur / COLS) + 1) * COLS % CELLS;
            end else begin
              e_we = 1'b1; e_addr = m_cur; e_data = m_attr * 256 + int'(bus.ch_data);
              m_cur = (m_cur + 1) % CELLS;
            end
            if (bus.ch_last) begin
              m_mode = M_IDLE; e_done = 1'b1;
            end
          end
        end
      endcase
    end
    e_busy  = (m_mode != M_IDLE);
    e_ready = (m_mode == M_STREAM);
  endfunction

  task automatic tick();
    bit in_rst;
    @(posedge clk);
    in_rst = rst;
    model_step();
    #1;
    check_eq("vram_we", bus.vram_we, e_we);
    if (e_we || in_rst) begin
      check_eq("vram_addr", bus.vram_addr, e_addr);
      check_eq("vram_data", bus.vram_data, e_data);
    end
    check_eq("done", bus.done, e_done);
    check_eq("busy", bus.busy, e_busy);
    check_eq("ch_ready", bus.ch_ready, e_ready);
    check_eq("disp_rst", bus.disp_rst, e_disp);
    if (bus.vram_we) begin
      log_addr.push_back(bus.vram_addr);
      log_data.push_back(bus.vram_data);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_mode != M_IDLE && n < 3000) begin
      tick();
      n++;
    end
    check_eq("reach_idle", (m_mode == M_IDLE), 1'b1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // gap_mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random gaps
  task automatic send_string(input int sa, input int a, input logic [7:0] chars[$],
                             input int gap_mode, input bit noise);
    bit prev_v;
    bus.ch_valid   = 1'b0;
    bus.start_addr = sa[ADDR_W-1:0];
    bus.attr       = a[7:0];
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    prev_v    = 1'b0;
    for (int i = 0; i < chars.size(); i++) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 64) begin
        case (gap_mode)
          0:       bus.ch_valid = 1'b1;
          1:       bus.ch_valid = ~prev_v;
          default: bus.ch_valid = ($urandom_range(0, 1) == 1);
        endcase
        prev_v      = bus.ch_valid;
        bus.ch_data = chars[i];
        bus.ch_last = (i == chars.size() - 1);
        if (noise) begin
          bus.start = ($urandom_range(0, 7) == 0);
          bus.clr   = ($urandom_range(0, 7) == 0);
        end
        acc = bus.ch_valid && bus.ch_ready;
        tick();
        guard++;
      end
      check_eq("xfer_accepted", acc, 1'b1);
    end
    bus.ch_valid = 1'b0;
    bus.ch_last  = 1'b0;
    bus.start    = 1'b0;
    bus.clr      = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [15:0] hello_exp[5];
    logic [31:0] wrap_exp[3];
    hello_exp = '{16'h3048, 16'h3065, 16'h306C, 16'h306C, 16'h306F};
    wrap_exp  = '{32'd2398, 32'd2399, 32'd0};

    rst = 1'b1;
    bus.start = 1'b0; bus.clr = 1'b0; bus.start_addr = '0; bus.attr = 8'h00;
    bus.ch_valid = 1'b0; bus.ch_data = 8'h00; bus.ch_last = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_log();
    wait_idle();
    check_eq("init_clear_n", log_addr.size(), CELLS);
    if (log_addr.size() > 0) begin
      check_eq("init_first_addr", log_addr[0], 32'd0);
      check_eq("init_last_addr", log_addr[log_addr.size() - 1], CELLS - 1);
    end
    tick();
    check_eq("disp_released", bus.disp_rst, 1'b0);

    // "Hello" at 0
    clear_log();
    q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    send_string(0, 8'h30, q, 0, 1'b0);
    tick();
    check_eq("hello_n", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      check_eq("hello_addr", log_addr[i], i);
      check_eq("hello_data", log_data[i], hello_exp[i]);
    end

    // wrap from the last cell to 0
    clear_log();
    q = '{8'h78, 8'h79, 8'h7A};
    send_string(2398, 8'h07, q, 0, 1'b0);
    tick();
    check_eq("wrap_n", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) check_eq("wrap_addr", log_addr[i], wrap_exp[i]);

    // newline handling
    clear_log();
    q = '{8'h41, 8'h0A, 8'h42};
    send_string(5, 8'h30, q, 1, 1'b0);
    tick();
    if (NL_EN) begin
      check_eq("nl_n", log_addr.size(), 2);
      if (log_addr.size() >= 2) begin
        check_eq("nl_a_addr", log_addr[0], 32'd5);
        check_eq("nl_b_addr", log_addr[1], 32'd80);
        check_eq("nl_b_data", log_data[1], 32'h3042);
      end
    end else begin
      check_eq("nonl_n", log_addr.size(), 3);
      if (log_addr.size() >= 3) begin
        check_eq("nonl_addr0", log_addr[0], 32'd5);
        check_eq("nonl_data1", log_data[1], 32'h300A);
        check_eq("nonl_addr2", log_addr[2], 32'd7);
      end
    end

    // random strings, start addresses, gaps and ignored requests
    for (int t = 0; t < 40; t++) begin
      int sa, len, sel;
      q.delete();
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++)
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255)));
      sel = $urandom_range(0, 7);
      if (sel < 2)       sa = $urandom_range(CELLS - 3, CELLS - 1);
      else if (sel == 2) sa = $urandom_range(CELLS, 4095);
      else               sa = $urandom_range(0, CELLS - 1);
      send_string(sa, $urandom_range(0, 255), q, $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(1, 3)) begin
        bus.ch_valid = ($urandom_range(0, 1) == 1);
        tick();
      end
      bus.ch_valid = 1'b0;
      if (t == 20) begin
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        wait_idle();
      end
    end

    // reset during a string, then clr and start together
    q = '{8'h61, 8'h62, 8'h63, 8'h64};
    bus.start_addr = 12'd100; bus.attr = 8'h11; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ch_valid = 1'b1; bus.ch_data = q[0];
    tick();
    bus.ch_data = q[1];
    tick();
    rst = 1'b1; bus.ch_data = q[2];
    tick();
    tick();
    rst = 1'b0; bus.ch_valid = 1'b0;
    clear_log();
    wait_idle();
    check_eq("rst_clear_n", log_addr.size(), CELLS);
    if (log_addr.size() > 0) check_eq("rst_clear_first", log_addr[0], 32'd0);
    tick();
    bus.clr = 1'b1; bus.start = 1'b1; bus.start_addr = 12'd7;
    tick();
    bus.clr = 1'b0; bus.start = 1'b0;
    check_eq("simul_busy", bus.busy, 1'b1);
    check_eq("simul_not_stream", bus.ch_ready, 1'b0);
    clear_log();
    wait_idle();
    check_eq("simul_clear_n", log_addr.size(), CELLS);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vram_init.md
VRAM_INIT -- requirements
Module: vram_init

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter ADDR_W, default 12, video RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS.
REQ-004 Parameter DATA_W, default 16, video RAM word width; must be >= 16.
REQ-005 Parameter FILL_WORD, default 16'h3000, word written to every cell during clear.
REQ-006 Parameter HOLD_CYCLES, default 8, minimum number of cycles disp_rst stays high after rst falls.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  IDLE only: begin a string write at start_addr.
REQ-010 clr  input  1  IDLE only: re-run the full-screen clear.
REQ-011 start_addr  input  ADDR_W  first cell of the string.
REQ-012 attr  input  8  attribute byte, sampled on start.
REQ-013 ch_valid / ch_data[7:0] / ch_last  input  1/8/1  character stream; ch_last marks the final character.
REQ-014 ch_ready  output  1  stream accept; a transfer occurs when ch_valid && ch_ready.
REQ-015 vram_addr / vram_data / vram_we  output  ADDR_W/DATA_W/1  registered video RAM write port.
REQ-016 disp_rst  output  1  reset to the display engine.
REQ-017 busy  output  1  high in CLEAR and STREAM.
REQ-018 done  output  1  one-cycle pulse at the end of a clear or a string.

Function
REQ-019 The FSM SHALL have states CLEAR, IDLE and STREAM.
REQ-020 CLEAR: writes FILL_WORD to addresses 0..COLS*ROWS-1 ascending, one write per cycle, then goes to IDLE with done pulsed.
REQ-021 IDLE: vram_we=0 and ch_ready=0; clr goes to CLEAR; start goes to STREAM; when clr and start are asserted together, clr wins.
REQ-022 start and clr outside IDLE SHALL be ignored, not queued.
REQ-023 On start, the cursor loads start_addr, or 0 if start_addr >= COLS*ROWS, and attr is latched.
REQ-024 STREAM: ch_ready=1; each transfer in cycle N produces vram_we=1 in cycle N+1 at the cursor address, with vram_data = {zeros, attr, ch_data}.
REQ-025 After each write the cursor increments, wrapping from COLS*ROWS-1 to 0.
REQ-026 A transfer with ch_last=1 is written like any other, then the FSM goes to IDLE with done pulsed in the same cycle as that final write.
REQ-027 disp_rst SHALL fall on the first cycle in which both the initial CLEAR has completed and HOLD_CYCLES cycles have elapsed since rst fell; it is never reasserted except by rst.
REQ-028 A later clr-triggered CLEAR SHALL leave disp_rst low.
REQ-029 vram_we SHALL be 0 in every cycle in which no write is defined.

Reset
REQ-030 While rst=1: FSM in CLEAR at address 0; vram_we=0, vram_addr=0, vram_data=0, ch_ready=0, done=0, busy=1, disp_rst=1.
REQ-031 rst asserted mid-CLEAR or mid-STREAM SHALL abort the operation; no further writes from it occur and the clear restarts at address 0.
REQ-032 The first clear write (address 0) SHALL appear in the first cycle after rst falls.

Configuration
REQ-033 Macro VRAM_INIT_NEWLINE_EN defined: a transfer with ch_data=8'h0A performs no write and moves the cursor to the first column of the next row, wrapping from the last row to row 0; ch_last on a newline still ends the string with done.
REQ-034 Macro VRAM_INIT_NEWLINE_EN undefined: 8'h0A is written as an ordinary character.

Verification
REQ-035 Defaults, rst high 3 cycles then low -> writes of 16'h3000 to addresses 0..2399 in cycles 1..2400; done=1 in cycle 2400; disp_rst=0 from cycle 2401.
REQ-036 start_addr=0, attr=8'h30, stream "Hello" with ch_last on 'o' -> writes 16'h3048, 3065, 306C, 306C, 306F to addresses 0..4; done pulses with the last write.
REQ-037 start_addr=2398, stream 3 chars -> writes to addresses 2398, 2399, 0.
REQ-038 With VRAM_INIT_NEWLINE_EN: start_addr=5, stream 'A', 0x0A, 'B' -> 'A' at 5, 'B' at 80, no write for 0x0A; without the macro -> writes to 5, 6, 7.
REQ-039 ch_valid toggling every other cycle during STREAM -> one write per transfer, vram_we=0 in gap cycles, no dropped or repeated characters.
REQ-040 rst pulsed mid-STREAM, then clr and start asserted together in IDLE -> clear restarts at address 0 with disp_rst=1 until it completes; the later simultaneous request runs CLEAR, not STREAM.
